// File: rtl/commit_store_queue.sv
// commit_store_queue
//   Commit-aware store queue between dispatch and the data-cache arbiter.
//   Stores are allocated in program order (up to SS per cycle) and receive
//   address/data/mask from execute by queue index. Only stores that the ROB
//   has committed and that are resolved drain through the mem_* valid/ready
//   handshake. A mispredict discards the uncommitted tail. Each dispatch lane
//   also receives the ROB tag of its youngest older store.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   mispredict                drop all uncommitted entries
//   disp_valid/is_store/rob   per-lane dispatch bundle (lanes contiguous from 0)
//   disp_ready                at least SS free entries
//   disp_idx                  queue index for each store lane
//   dep_valid/dep_rob         youngest older store per lane
//   ex_valid/idx/addr/data/mask  execute-stage write into a live entry
//   commit_cnt                stores retired by the ROB this cycle
//   mem_valid/ready/addr/data/mask/rob  head store to the arbiter
//   sq_free, sq_empty         occupancy status (registered state only)
module commit_store_queue #(
    parameter int DEPTH    = 8,
    parameter int SS       = 2,
    parameter int WIDTH    = 32,
    parameter int ROB_BITS = 5,
    localparam int DB      = $clog2(DEPTH),
    localparam int SB      = $clog2(SS),
    localparam int MW      = WIDTH / 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   mispredict,
    input  logic [SS-1:0]          disp_valid,
    input  logic [SS-1:0]          disp_is_store,
    input  logic [SS*ROB_BITS-1:0] disp_rob,
    output logic                   disp_ready,
    output logic [SS*DB-1:0]       disp_idx,
    output logic [SS-1:0]          dep_valid,
    output logic [SS*ROB_BITS-1:0] dep_rob,
    input  logic                   ex_valid,
    input  logic [DB-1:0]          ex_idx,
    input  logic [WIDTH-1:0]       ex_addr,
    input  logic [WIDTH-1:0]       ex_data,
    input  logic [MW-1:0]          ex_mask,
    input  logic [SB:0]            commit_cnt,
    output logic                   mem_valid,
    input  logic                   mem_ready,
    output logic [WIDTH-1:0]       mem_addr,
    output logic [WIDTH-1:0]       mem_data,
    output logic [MW-1:0]          mem_mask,
    output logic [ROB_BITS-1:0]    mem_rob,
    output logic [DB:0]            sq_free,
    output logic                   sq_empty
);

    // Pointers carry a wrap bit so that full and empty are distinguishable.
    logic [DB:0]          head_q, head_d, cmt_q, cmt_d, tail_q, tail_d;
    logic [ROB_BITS-1:0]  rob_q  [DEPTH];
    logic [ROB_BITS-1:0]  rob_d  [DEPTH];
    logic [WIDTH-1:0]     addr_q [DEPTH];
    logic [WIDTH-1:0]     addr_d [DEPTH];
    logic [WIDTH-1:0]     data_q [DEPTH];
    logic [WIDTH-1:0]     data_d [DEPTH];
    logic [MW-1:0]        mask_q [DEPTH];
    logic [MW-1:0]        mask_d [DEPTH];
    logic [DEPTH-1:0]     resolved_q, resolved_d;

    logic [DB:0]          count, ccnt_post, cc_ext;
    logic [DB-1:0]        head_idx, tail_last, ex_off, widx;
    logic [SS-1:0]        is_st;
    logic [DB:0]          st_off [SS+1];
    logic                 pop, disp_fire, ex_live, ex_ok;

    assign count      = tail_q - head_q;
    assign sq_free    = (DB+1)'(DEPTH) - count;
    assign sq_empty   = (count == '0);
    assign disp_ready = (sq_free >= (DB+1)'(SS));
    assign head_idx   = head_q[DB-1:0];
    assign tail_last  = tail_q[DB-1:0] - DB'(1);
    assign mem_valid  = (head_q != cmt_q) & resolved_q[head_idx];
    assign mem_addr   = addr_q[head_idx];
    assign mem_data   = data_q[head_idx];
    assign mem_mask   = mask_q[head_idx];
    assign mem_rob    = rob_q[head_idx];
    assign pop        = mem_valid & mem_ready;
    assign disp_fire  = disp_ready & ~mispredict;
    assign is_st      = disp_valid & disp_is_store;
    assign cc_ext     = (DB+1)'(commit_cnt);

    // An execute write under mispredict survives only if the entry is
    // committed once this cycle's commit_cnt has been applied.
    assign ex_off     = ex_idx - head_idx;
    assign ex_live    = ((DB+1)'(ex_off) < count);
    assign ccnt_post  = (cmt_q - head_q) + cc_ext;
    assign ex_ok      = ex_valid & ex_live & ~(mispredict & ((DB+1)'(ex_off) >= ccnt_post));

    // Index assignment and per-lane dependency tags.
    always_comb begin
        disp_idx  = '0;
        dep_valid = '0;
        dep_rob   = '0;
        st_off[0] = '0;
        for (int unsigned i = 0; i < SS; i++) begin
            st_off[i+1] = st_off[i] + (DB+1)'(is_st[i]);
            disp_idx[i*DB +: DB] = tail_q[DB-1:0] + st_off[i][DB-1:0];
        end
        for (int unsigned i = 0; i < SS; i++) begin
            // Later j overwrites earlier, leaving the youngest older store.
            for (int unsigned j = 0; j < i; j++) begin
                if (is_st[j]) begin
                    dep_valid[i] = 1'b1;
                    dep_rob[i*ROB_BITS +: ROB_BITS] = disp_rob[j*ROB_BITS +: ROB_BITS];
                end
            end
            if (!dep_valid[i] && (count > (DB+1)'(pop))) begin
                dep_valid[i] = 1'b1;
                dep_rob[i*ROB_BITS +: ROB_BITS] = rob_q[tail_last];
            end
        end
    end

    // Next-state: dispatch, execute write, issue pop, commit, mispredict.
    always_comb begin
        head_d     = head_q;
        cmt_d      = cmt_q + cc_ext;
        tail_d     = tail_q;
        rob_d      = rob_q;
        addr_d     = addr_q;
        data_d     = data_q;
        mask_d     = mask_q;
        resolved_d = resolved_q;
        widx       = '0;
        if (disp_fire) begin
            for (int unsigned i = 0; i < SS; i++) begin
                if (is_st[i]) begin
                    widx             = disp_idx[i*DB +: DB];
                    rob_d[widx]      = disp_rob[i*ROB_BITS +: ROB_BITS];
                    resolved_d[widx] = 1'b0;
                end
            end
            tail_d = tail_q + st_off[SS];
        end
        if (ex_ok) begin
            addr_d[ex_idx]     = ex_addr;
            data_d[ex_idx]     = ex_data;
            mask_d[ex_idx]     = ex_mask;
            resolved_d[ex_idx] = 1'b1;
        end
        if (pop) begin
            resolved_d[head_idx] = 1'b0;
            head_d               = head_q + (DB+1)'(1);
        end
        if (mispredict) begin
            tail_d = cmt_q + cc_ext;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q     <= '0;
            cmt_q      <= '0;
            tail_q     <= '0;
            resolved_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                rob_q[i]  <= '0;
                addr_q[i] <= '0;
                data_q[i] <= '0;
                mask_q[i] <= '0;
            end
        end else begin
            head_q     <= head_d;
            cmt_q      <= cmt_d;
            tail_q     <= tail_d;
            resolved_q <= resolved_d;
            rob_q      <= rob_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            mask_q     <= mask_d;
        end
    end

endmodule

// File: tb/tb_commit_store_queue.sv
// Self-checking bench for commit_store_queue: directed steps followed by
// randomized traffic, checked against a queue-based reference model.
module tb_commit_store_queue;
    localparam int DEPTH = 8;
    localparam int SS    = 2;
    localparam int WIDTH = 32;
    localparam int RB    = 5;
    localparam int DB    = 3;

    logic            clk = 1'b0;
    logic            rst, mispredict;
    logic [SS-1:0]   disp_valid, disp_is_store;
    logic [SS*RB-1:0] disp_rob;
    logic            disp_ready;
    logic [SS*DB-1:0] disp_idx;
    logic [SS-1:0]   dep_valid;
    logic [SS*RB-1:0] dep_rob;
    logic            ex_valid;
    logic [DB-1:0]   ex_idx;
    logic [WIDTH-1:0] ex_addr, ex_data;
    logic [3:0]      ex_mask;
    logic [1:0]      commit_cnt;
    logic            mem_valid, mem_ready;
    logic [WIDTH-1:0] mem_addr, mem_data;
    logic [3:0]      mem_mask;
    logic [RB-1:0]   mem_rob;
    logic [DB:0]     sq_free;
    logic            sq_empty;

    commit_store_queue #(.DEPTH(DEPTH), .SS(SS), .WIDTH(WIDTH), .ROB_BITS(RB)) dut (
        .clk(clk), .rst(rst), .mispredict(mispredict),
        .disp_valid(disp_valid), .disp_is_store(disp_is_store), .disp_rob(disp_rob),
        .disp_ready(disp_ready), .disp_idx(disp_idx),
        .dep_valid(dep_valid), .dep_rob(dep_rob),
        .ex_valid(ex_valid), .ex_idx(ex_idx), .ex_addr(ex_addr), .ex_data(ex_data),
        .ex_mask(ex_mask), .commit_cnt(commit_cnt),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_data(mem_data), .mem_mask(mem_mask), .mem_rob(mem_rob),
        .sq_free(sq_free), .sq_empty(sq_empty)
    );

    always #5 clk = ~clk;

    // Reference model: program-ordered list of live stores, oldest first.
    typedef struct {
        logic [RB-1:0]    rob;
        logic [WIDTH-1:0] addr;
        logic [WIDTH-1:0] data;
        logic [3:0]       mask;
        bit               res;
    } ent_t;

    ent_t mq[$];
    int   ncmt  = 0;   // number of committed entries at the front of mq
    int   mhead = 0;   // physical index of mq[0]
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit m_mv();
        if (ncmt == 0) return 1'b0;
        return mq[0].res;
    endfunction

    task automatic check_outputs();
        int sz, k;
        bit mv, found;
        logic [RB-1:0] er;
        sz = mq.size();
        mv = m_mv();
        chk("sq_free", sq_free, DEPTH - sz);
        chk("sq_empty", sq_empty, sz == 0);
        chk("disp_ready", disp_ready, (DEPTH - sz) >= SS);
        chk("mem_valid", mem_valid, mv);
        if (mv) begin
            chk("mem_addr", mem_addr, mq[0].addr);
            chk("mem_data", mem_data, mq[0].data);
            chk("mem_mask", mem_mask, mq[0].mask);
            chk("mem_rob", mem_rob, mq[0].rob);
        end
        k = 0;
        for (int i = 0; i < SS; i++) begin
            if (disp_valid[i] && disp_is_store[i]) begin
                chk("disp_idx", disp_idx[i*DB +: DB], (mhead + sz + k) % DEPTH);
                k++;
            end
        end
        for (int i = 0; i < SS; i++) begin
            found = 1'b0;
            er = '0;
            for (int j = 0; j < i; j++)
                if (disp_valid[j] && disp_is_store[j]) begin
                    found = 1'b1;
                    er = disp_rob[j*RB +: RB];
                end
            if (!found && (sz - ((mv && mem_ready) ? 1 : 0)) > 0) begin
                found = 1'b1;
                er = mq[sz-1].rob;
            end
            chk("dep_valid", dep_valid[i], found);
            chk("dep_rob", dep_rob[i*RB +: RB], er);
        end
    endtask

    task automatic model_step();
        int sz, off;
        bit pop;
        ent_t e;
        if (rst) begin
            mq.delete();
            ncmt  = 0;
            mhead = 0;
            return;
        end
        sz  = mq.size();
        pop = m_mv() && mem_ready;
        if (!mispredict && ((disp_valid & disp_is_store) != '0))
            chk("disp_legal", disp_ready, 1'b1);
        if (ex_valid) begin
            off = (int'(ex_idx) - mhead + DEPTH) % DEPTH;
            if (off < sz && !(mispredict && off >= ncmt + int'(commit_cnt))) begin
                e = mq[off];
                e.addr = ex_addr; e.data = ex_data; e.mask = ex_mask; e.res = 1'b1;
                mq[off] = e;
            end
        end
        if (pop) begin
            void'(mq.pop_front());
            ncmt--;
            mhead = (mhead + 1) % DEPTH;
        end
        ncmt += int'(commit_cnt);
        if (mispredict) begin
            while (mq.size() > ncmt) void'(mq.pop_back());
        end else if ((DEPTH - sz) >= SS) begin
            for (int i = 0; i < SS; i++)
                if (disp_valid[i] && disp_is_store[i]) begin
                    e.rob = disp_rob[i*RB +: RB];
                    e.addr = '0; e.data = '0; e.mask = '0; e.res = 1'b0;
                    mq.push_back(e);
                end
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        check_outputs();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        mispredict = 0; disp_valid = '0; disp_is_store = '0; disp_rob = '0;
        ex_valid = 0; ex_idx = '0; ex_addr = '0; ex_data = '0; ex_mask = '0;
        commit_cnt = '0; mem_ready = 0;
    endtask

    task automatic set_disp(input logic [1:0] v, input logic [1:0] s,
                            input logic [RB-1:0] r0, input logic [RB-1:0] r1);
        disp_valid = v; disp_is_store = s; disp_rob = {r1, r0};
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        cycle();
        cycle();
        rst = 0;
    endtask

    // Physical index of the oldest unresolved live entry, or -1.
    function automatic int first_unres();
        for (int i = 0; i < mq.size(); i++)
            if (!mq[i].res) return (mhead + i) % DEPTH;
        return -1;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int fu, last_idx, n, off;
        bit saw_wrap, saw_notready;
        logic [RB-1:0] seq;
        logic [1:0] v, s;

        // Reset state
        do_reset();
        chk("rst_free", sq_free, 8);
        chk("rst_empty", sq_empty, 1);
        chk("rst_ready", disp_ready, 1);
        chk("rst_mem_valid", mem_valid, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_data", mem_data, 0);
        chk("rst_mem_rob", mem_rob, 0);
        chk("rst_dep_valid", dep_valid, 0);

        // Two stores in one bundle
        set_disp(2'b11, 2'b11, 5'd3, 5'd4);
        #1 chk("t1_idx", disp_idx, {3'd1, 3'd0});
        cycle();
        idle();
        chk("t1_free", sq_free, 6);
        chk("t1_empty", sq_empty, 0);

        // Store then load: load depends on lane-0 store
        set_disp(2'b11, 2'b01, 5'd7, 5'd9);
        #1 chk("t2_dep1_v", dep_valid[1], 1);
        chk("t2_dep1_rob", dep_rob[9:5], 7);
        chk("t2_dep0_rob", dep_rob[4:0], 4);
        cycle();
        idle();

        // Resolve + commit head, then hold the arbiter off
        ex_valid = 1; ex_idx = 0; ex_addr = 32'h100; ex_data = 32'hDEADBEEF; ex_mask = 4'hF;
        commit_cnt = 1;
        cycle();
        idle();
        chk("t3_mv", mem_valid, 1);
        chk("t3_addr", mem_addr, 32'h100);
        chk("t3_data", mem_data, 32'hDEADBEEF);
        chk("t3_mask", mem_mask, 4'hF);
        chk("t3_rob", mem_rob, 3);
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("t3_hold_mv", mem_valid, 1);
            chk("t3_hold_addr", mem_addr, 32'h100);
            chk("t3_hold_data", mem_data, 32'hDEADBEEF);
        end
        mem_ready = 1;
        cycle();
        idle();
        chk("t3_after_mv", mem_valid, 0);
        chk("t3_after_free", sq_free, 6);

        // Mispredict keeps only the committed entry, which still drains
        do_reset();
        set_disp(2'b11, 2'b11, 5'd1, 5'd2);
        cycle();
        set_disp(2'b01, 2'b01, 5'd5, 5'd0);
        cycle();
        idle();
        commit_cnt = 1;
        cycle();
        idle();
        mispredict = 1;
        cycle();
        idle();
        chk("t4_free", sq_free, 7);
        ex_valid = 1; ex_idx = 0; ex_addr = 32'h2000; ex_data = 32'h1234_5678; ex_mask = 4'h3;
        cycle();
        idle();
        chk("t4_mv", mem_valid, 1);
        chk("t4_rob", mem_rob, 1);
        mem_ready = 1;
        cycle();
        idle();
        chk("t4_empty", sq_empty, 1);
        set_disp(2'b11, 2'b00, 5'd8, 5'd9);
        #1 chk("t4_loads_dep", dep_valid, 2'b00);
        cycle();
        idle();
        chk("t4_loads_empty", sq_empty, 1);

        // Mispredict with same-cycle commit and dispatch
        do_reset();
        set_disp(2'b11, 2'b11, 5'd10, 5'd11);
        cycle();
        set_disp(2'b01, 2'b01, 5'd12, 5'd0);
        cycle();
        idle();
        mispredict = 1; commit_cnt = 1;
        set_disp(2'b01, 2'b01, 5'd13, 5'd0);
        cycle();
        idle();
        chk("t5_free", sq_free, 7);
        ex_valid = 1; ex_idx = 0; ex_addr = 32'h44; ex_data = 32'h55; ex_mask = 4'h1;
        cycle();
        idle();
        chk("t5_kept_mv", mem_valid, 1);
        chk("t5_kept_rob", mem_rob, 10);

        // Streaming: 2 in, 1 out per cycle until the queue wraps and fills
        do_reset();
        seq = '0; last_idx = -1; saw_wrap = 0; saw_notready = 0;
        for (int c = 0; c < 40; c++) begin
            idle();
            mem_ready = 1;
            if (!disp_ready) saw_notready = 1;
            if ((DEPTH - mq.size()) >= SS) begin
                set_disp(2'b11, 2'b11, seq, seq + 5'd1);
                seq = seq + 5'd2;
                #0;
                for (int i = 0; i < SS; i++) begin
                    n = int'(disp_idx[i*DB +: DB]);
                    if (last_idx == DEPTH - 1 && n == 0) saw_wrap = 1;
                    last_idx = n;
                end
            end
            fu = first_unres();
            if (fu >= 0) begin
                ex_valid = 1; ex_idx = DB'(fu); ex_addr = $urandom; ex_data = $urandom;
                ex_mask = 4'($urandom);
            end
            if (mq.size() - ncmt > 0) commit_cnt = 1;
            cycle();
        end
        idle();
        chk("t6_wrap", saw_wrap, 1);
        chk("t6_notready", saw_notready, 1);

        // Randomized traffic with occasional mispredict and reset
        do_reset();
        for (int c = 0; c < 600; c++) begin
            idle();
            rst = ($urandom_range(0, 99) == 0);
            mispredict = ($urandom_range(0, 15) == 0);
            mem_ready = $urandom_range(0, 2) != 0;
            n = $urandom_range(0, SS);
            v = (n == 2) ? 2'b11 : (n == 1) ? 2'b01 : 2'b00;
            s = 2'($urandom) & v;
            if ((DEPTH - mq.size()) < SS && !mispredict && !rst) s = 2'b00;
            set_disp(v, s, 5'($urandom), 5'($urandom));
            n = mq.size() - ncmt;
            if (n > SS) n = SS;
            commit_cnt = 2'($urandom_range(0, n));
            if ($urandom_range(0, 1) == 1) begin
                ex_idx = 3'($urandom);
                off = (int'(ex_idx) - mhead + DEPTH) % DEPTH;
                // Rewriting an already-resolved live entry is not a legal execute event.
                if (!(off < mq.size() && mq[off].res)) begin
                    ex_valid = 1; ex_addr = $urandom; ex_data = $urandom; ex_mask = 4'($urandom);
                end
            end
            cycle();
        end
        idle();
        rst = 0;
        cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/commit_store_queue.md
# commit_store_queue

Parametrised, commit-aware store queue that replaces the single-stage store FIFO between dispatch and the data-cache arbiter. It allocates up to SS stores per cycle in program order and captures address/data/mask from the execute stage by queue index. Only ROB-committed, resolved stores drain to memory through a valid/ready handshake. A mispredict discards only uncommitted entries, and the block supplies per-lane youngest-older-store dependency tags to dispatched loads.

## Interface
- DEPTH, 8: entries; power of two, ≥ 2; DB = $clog2(DEPTH)
- SS, 2: dispatch/commit lanes; SB = $clog2(SS)
- WIDTH, 32: address and data width; mask width WIDTH/8
- ROB_BITS, 5: ROB tag width
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- mispredict  in  1  flush all uncommitted entries
- disp_valid  in  SS  lane valid (lanes contiguous from 0)
- disp_is_store  in  SS  lane is a store; loads do not allocate
- disp_rob  in  SS×ROB_BITS  ROB tag per lane
- disp_ready  out  1  sq_free ≥ SS
- disp_idx  out  SS×DB  queue index assigned to each store lane
- dep_valid  out  SS  an older store exists for the lane
- dep_rob  out  SS×ROB_BITS  ROB tag of the youngest older store
- ex_valid  in  1  execute write
- ex_idx  in  DB  target entry
- ex_addr, ex_data  in  WIDTH  resolved address and data
- ex_mask  in  WIDTH/8  byte enables
- commit_cnt  in  SB+1  stores retired by the ROB this cycle, ≤ uncommitted count
- mem_valid  out  1  head store ready to write
- mem_ready  in  1  arbiter accepts
- mem_addr, mem_data  out  WIDTH; mem_mask  out  WIDTH/8; mem_rob  out  ROB_BITS
- sq_free  out  DB+1  free entries
- sq_empty  out  1  no live entries

## Operation
- Pointers head, cmt, tail are DB+1 bits wide; the MSB is the wrap bit; index = low DB bits. count = tail−head. Invariant: head ≤ cmt ≤ tail (modular).
- Per-entry state: rob, addr, data, mask, resolved.
- Dispatch: a write is an accepted lane with disp_valid & disp_is_store. Store k (0-based among that cycle's stores) goes to index tail+k. disp_idx[i] = tail + (number of stores in lanes < i), computed combinationally. Tail advances by the number of stores. The write clears resolved.
- Dispatch while disp_ready=0 is illegal (bench asserts).
- Execute: on ex_valid, write addr/data/mask into entry ex_idx and set resolved. Ignore the write if ex_idx is not live (not in [head, tail)) or if mispredict is high in the same cycle and the entry is uncommitted.
- Commit: cmt += commit_cnt.
- Issue: mem_valid = (head≠cmt) & resolved[head]. The mem_* outputs come from entry head and are driven only from registered state. On mem_valid & mem_ready: head+1 and clear resolved[head].
- Mispredict: tail ← cmt + commit_cnt (the same-cycle commit counts first). Dispatch in that cycle is dropped. Issue and commit proceed normally.
- Dependency, combinational, per lane i:
  - If some lane j<i is a valid store, report the rob of the largest such j.
  - Else, if the queue holds at least one entry after this cycle's pop, report rob[tail−1].
  - Else dep_valid[i]=0 and dep_rob[i]=0.
- sq_free = DEPTH − count. sq_empty = (count==0). Both are registered-state functions with no same-cycle bypass.

## Timing
- Reset values: head=cmt=tail=0; all resolved=0; mem_valid=0; mem_* = 0; sq_free=DEPTH; sq_empty=1; disp_ready=1; dep_valid=0.
- Latency:
  - Dispatch → visible in count, sq_free, and dep: next cycle.
  - ex write → mem_valid (if committed and at head): next cycle.
  - commit → mem_valid: next cycle.
- mem_* must stay stable while mem_valid=1 and mem_ready=0. A mispredict never deasserts mem_valid.
- Full case: count==DEPTH gives sq_free=0. Issue and dispatch in the same cycle: dispatch uses the pre-pop free count.
- Wrap: index arithmetic is mod DEPTH; the full/empty distinction relies on the wrap bit.
- rst asserted mid-operation overrides every other input that cycle.

## Test plan
- Reset, then SS=2 dispatch of {store rob 3, store rob 4} → disp_idx={0,1}; next cycle sq_free=DEPTH−2, sq_empty=0.
- Dispatch {store rob 7, load} → lane 1 dep_valid=1, dep_rob=7. Into an empty queue, a bundle {load, load} → dep_valid=00.
- ex write idx 0 (addr 0x100, data 0xDEADBEEF, mask 0xF); commit_cnt=1 → mem_valid next cycle with those values. Hold mem_ready=0 for 3 cycles and check stable outputs; then ready=1 → head=1.
- 3 stores dispatched, 1 committed, mispredict → tail=cmt; sq_free=DEPTH−1; the committed store still drains.
- Dispatch 2 stores every cycle with issue 1 per cycle until wrap → indices wrap 7→0, no loss; disp_ready drops at sq_free<2.
- Mispredict in the same cycle as commit_cnt=1 and a dispatch → the committed entry is kept, the dispatch is dropped, and tail = old cmt+1.
